// File: rtl/mux2to1_arbiter.sv
// Arbiter for two requesters sharing one 2:1 mux: round-robin with bounded hold and a one-cycle TURN gap.
// Optional build macro MUX_ARB_FIXED_PRIO_EN: A has fixed priority and only B is preempted.
module mux2to1_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic       busy,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_q, last_d;   // 0 = A owned last, 1 = B owned last

    logic a_wins_tie;
    logic a_preemptible;
    logic at_limit;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign a_wins_tie    = 1'b1;
    assign a_preemptible = 1'b0;
`else
    assign a_wins_tie    = last_q;
    assign a_preemptible = 1'b1;
`endif

    assign at_limit = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || a_wins_tie)) begin
                    state_d = ST_OWN_A;
                    sel_d   = 1'b0;
                end else if (req_b) begin
                    state_d = ST_OWN_B;
                    sel_d   = 1'b1;
                end
            end
            ST_OWN_A: begin
                if (req_b && (!req_a || (a_preemptible && at_limit))) begin
                    state_d = ST_TURN;
                    sel_d   = 1'b1;
                end else if (!req_a) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_B: begin
                if (req_a && (!req_b || at_limit)) begin
                    state_d = ST_TURN;
                    sel_d   = 1'b0;
                end else if (!req_b) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                // sel already points at the target; the previous owner is the other side.
                if (sel_q ? req_b : req_a) begin
                    state_d = sel_q ? ST_OWN_B : ST_OWN_A;
                end else if (sel_q ? req_a : req_b) begin
                    state_d = sel_q ? ST_OWN_A : ST_OWN_B;
                    sel_d   = ~sel_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_a_d    = (state_d == ST_OWN_A);
        gnt_b_d    = (state_d == ST_OWN_B);
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        if ((gnt_a_d || gnt_b_d) && (state_d != state_q)) begin
            hold_cnt_d = '0;
            last_d     = gnt_b_d;
        end else if ((gnt_a_d || gnt_b_d) && !at_limit) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            sel_q      <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign sel     = sel_q;
    assign busy    = gnt_a_q | gnt_b_q;
    assign state_o = state_q;

endmodule
